reg_fifo_ctrl: RTL and testbench

Frame sequencer for the input-layer byte FIFO (`reg_fifo`: 64-bit push, 24-bit pop, 4-bit byte count).
- Accepts 64-bit words from an upstream valid/ready stream and drives `fifo_push` and `fifo_pop`.
- Presents 24-bit pixels downstream with valid/ready.
- Tracks FIFO byte occupancy locally so the FIFO never overflows or underflows.
- Bounds each frame to a programmed pixel count, then flushes leftover bytes and signals done.

---
 rtl/reg_fifo_ctrl.sv | 164 ++++++++++++++++
 tb/tb_reg_fifo_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_fifo_ctrl.sv
// reg_fifo_ctrl: frame sequencer for the input-layer byte FIFO (reg_fifo).
// Accepts IN_BYTES-wide words upstream, emits OUT_BYTES-wide pixels downstream,
// tracks FIFO occupancy locally and flushes leftover bytes at end of frame.
// Optional build macro REG_FIFO_CTRL_CHECK_EN adds a sticky occupancy check
// (fifo_count vs. local occupancy) on the err output; without it err is 0.
module reg_fifo_ctrl #(
  parameter int unsigned IN_BYTES   = 8,
  parameter int unsigned OUT_BYTES  = 3,
  parameter int unsigned FIFO_DEPTH = 15,
  parameter int unsigned PIX_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [PIX_W-1:0]         num_pix,
  input  logic [8*IN_BYTES-1:0]    s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [8*IN_BYTES-1:0]    fifo_data_in,
  output logic                     fifo_push,
  output logic                     fifo_pop,
  output logic                     fifo_flush,
  input  logic [3:0]               fifo_count,
  input  logic [8*OUT_BYTES-1:0]   fifo_data_o,
  output logic [8*OUT_BYTES-1:0]   m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned OCC_W    = 4;
  localparam int unsigned WCNT_W   = PIX_W + 2;
  localparam int unsigned IN_SHIFT = $clog2(IN_BYTES);

  localparam logic [OCC_W-1:0] IN_B     = OCC_W'(IN_BYTES);
  localparam logic [OCC_W-1:0] OUT_B    = OCC_W'(OUT_BYTES);
  localparam logic [OCC_W-1:0] PUSH_MAX = OCC_W'(FIFO_DEPTH - IN_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_t;

  state_t              state, state_nxt;
  logic [OCC_W-1:0]    occ, occ_nxt;
  logic [PIX_W-1:0]    pix_left, pix_nxt;
  logic [WCNT_W-1:0]   words_left, words_nxt;
  logic [WCNT_W-1:0]   words_load;
  logic                busy_nxt, done_nxt, flush_nxt;
  logic                run_st;

  // Words needed to carry num_pix pixels, rounded up to whole pushes.
  assign words_load = (WCNT_W'(num_pix) * WCNT_W'(OUT_BYTES) + WCNT_W'(IN_BYTES - 1))
                      >> IN_SHIFT;

  // Handshake and pass-through; a same-cycle pop earns no push credit.
  assign run_st       = (state == ST_RUN);
  assign s_ready      = run_st && (words_left != '0) && (occ <= PUSH_MAX);
  assign fifo_push    = s_valid && s_ready;
  assign m_valid      = run_st && (pix_left != '0) && (occ >= OUT_B);
  assign fifo_pop     = m_valid && m_ready;
  assign fifo_data_in = s_data;
  assign m_data       = fifo_data_o;

  // State register plus counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      occ        <= '0;
      pix_left   <= '0;
      words_left <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fifo_flush <= 1'b0;
    end else begin
      state      <= state_nxt;
      occ        <= occ_nxt;
      pix_left   <= pix_nxt;
      words_left <= words_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      fifo_flush <= flush_nxt;
    end
  end

  // Next-state, counter updates and next values of registered outputs.
  always_comb begin
    state_nxt = state;
    occ_nxt   = occ;
    pix_nxt   = pix_left;
    words_nxt = words_left;
    done_nxt  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          if (num_pix != '0) begin
            state_nxt = ST_RUN;
            occ_nxt   = '0;
            pix_nxt   = num_pix;
            words_nxt = words_load;
          end else begin
            done_nxt  = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (fifo_push) begin
          occ_nxt   = occ_nxt + IN_B;
          words_nxt = words_left - WCNT_W'(1);
        end
        if (fifo_pop) begin
          occ_nxt = occ_nxt - OUT_B;
          pix_nxt = pix_left - PIX_W'(1);
          if (pix_left == PIX_W'(1)) begin
            state_nxt = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        occ_nxt   = '0;
        state_nxt = ST_IDLE;
        done_nxt  = 1'b1;
      end

      default: begin
        state_nxt = ST_IDLE;
        occ_nxt   = '0;
      end
    endcase

    busy_nxt  = (state_nxt != ST_IDLE);
    flush_nxt = (state_nxt == ST_FLUSH);
  end

`ifdef REG_FIFO_CTRL_CHECK_EN
  logic err_q;

  // Sticky occupancy check; cleared by reset or an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if ((state == ST_IDLE) && start) begin
      err_q <= 1'b0;
    end else if (run_st && (fifo_count != occ)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_fifo_count;

  // No checker in this build; fifo_count is observed only by the checker.
  assign unused_fifo_count = ^fifo_count;
  assign err               = 1'b0;
`endif

endmodule

// File: tb/tb_reg_fifo_ctrl.sv
// Testbench for reg_fifo_ctrl: models reg_fifo as an LSB-first byte queue and
// checks handshakes, pixel data and frame sequencing against byte/pixel counts.
module tb_reg_fifo_ctrl;

  localparam int unsigned PIX_W = 16;
`ifdef REG_FIFO_CTRL_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, start;
  logic [PIX_W-1:0] num_pix;
  logic [63:0]      s_data;
  logic             s_valid, s_ready;
  logic [63:0]      fifo_data_in;
  logic             fifo_push, fifo_pop, fifo_flush;
  logic [3:0]       fifo_count;
  logic [23:0]      fifo_data_o, m_data;
  logic             m_valid, m_ready, busy, done, err;

  always #5 clk = ~clk;

  reg_fifo_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_pix      (num_pix),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .fifo_data_in (fifo_data_in),
    .fifo_push    (fifo_push),
    .fifo_pop     (fifo_pop),
    .fifo_flush   (fifo_flush),
    .fifo_count   (fifo_count),
    .fifo_data_o  (fifo_data_o),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  logic [7:0]  byte_q[$];
  int          skew;
  bit          exp_err;

  int opt_hold, opt_restart_at, opt_abort_pops, opt_skew_at, opt_vp, opt_rp;
  bit opt_directed;

  logic        smp_push, smp_pop, smp_sready, smp_mvalid, smp_flush;
  logic [23:0] smp_mdata;
  logic [63:0] smp_din;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Drive the FIFO-model outputs from the byte queue (plus an optional count skew).
  function automatic void drive_fifo();
    logic [23:0] d;
    d = '0;
    for (int i = 0; i < 3; i++)
      if (i < byte_q.size()) d[8*i +: 8] = byte_q[i];
    fifo_data_o = d;
    fifo_count  = 4'(byte_q.size() + skew);
  endfunction

  // One clock: sample combinational outputs, cross the edge, update the FIFO model.
  task automatic tick();
    #2;
    if (reset || fifo_flush) begin
      byte_q.delete();
      drive_fifo();
      #1;
    end
    smp_push   = fifo_push;
    smp_pop    = fifo_pop;
    smp_sready = s_ready;
    smp_mvalid = m_valid;
    smp_flush  = fifo_flush;
    smp_mdata  = m_data;
    smp_din    = fifo_data_in;
    @(posedge clk);
    #1;
    if (!reset && !smp_flush) begin
      if (smp_pop) begin
        check_eq("fifo_underflow", 64'(byte_q.size() >= 3), 64'd1);
        for (int i = 0; i < 3; i++)
          if (byte_q.size() > 0) void'(byte_q.pop_front());
      end
      if (smp_push) begin
        for (int b = 0; b < 8; b++) byte_q.push_back(smp_din[8*b +: 8]);
        check_eq("fifo_overflow", 64'(byte_q.size() <= 15), 64'd1);
      end
    end
    drive_fifo();
  endtask

  task automatic reset_abort();
    reset = 1'b1; s_valid = 1'b1; m_ready = 1'b1; start = 1'b0; skew = 0;
    drive_fifo();
    tick();
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_flush", 64'(fifo_flush), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_fifo_empty", 64'(byte_q.size()), 64'd0);
    exp_err = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("post_rst_s_ready", 64'(smp_sready), 64'd0);
      check_eq("post_rst_m_valid", 64'(smp_mvalid), 64'd0);
      check_eq("post_rst_done", 64'(done), 64'd0);
      check_eq("post_rst_busy", 64'(busy), 64'd0);
    end
  endtask

  task automatic run_frame(input int n);
    logic [63:0] words[$];
    logic [7:0]  bytes[$];
    logic [23:0] first_px[2];
    logic [23:0] px;
    logic [63:0] w;
    int nw, pushes, pops, cyc, occ, push_occ2, peak;
    bit fin;
    nw = (3 * n + 7) / 8;
    pushes = 0; pops = 0; cyc = 0; push_occ2 = -1; peak = 0; fin = 1'b0;
    first_px[0] = '0; first_px[1] = '0;
    for (int i = 0; i < nw; i++) begin
      w = (opt_directed && i == 0) ? 64'h2343253267384758 : {$urandom, $urandom};
      words.push_back(w);
      for (int b = 0; b < 8; b++) bytes.push_back(w[8*b +: 8]);
    end

    start = 1'b1; num_pix = PIX_W'(n); skew = 0;
    s_valid = 1'($urandom_range(1)); m_ready = 1'($urandom_range(1)); s_data = words[0];
    drive_fifo();
    tick();
    start = 1'b0;
    check_eq("idle_s_ready", 64'(smp_sready), 64'd0);
    check_eq("idle_m_valid", 64'(smp_mvalid), 64'd0);
    check_eq("idle_push", 64'(smp_push), 64'd0);
    exp_err = 1'b0;
    check_eq("start_busy", 64'(busy), 64'd1);
    check_eq("start_done", 64'(done), 64'd0);
    check_eq("start_err", 64'(err), 64'(exp_err));

    while (!fin && cyc < 2000) begin
      occ     = 8 * pushes - 3 * pops;
      s_valid = (cyc < opt_hold) ? 1'b1 : ($urandom_range(99) < opt_vp);
      m_ready = (cyc < opt_hold) ? 1'b0 : ($urandom_range(99) < opt_rp);
      s_data  = (pushes < nw) ? words[pushes] : {$urandom, $urandom};
      start   = (cyc == opt_restart_at);
      num_pix = PIX_W'($urandom_range(1, 100));
      skew    = (cyc == opt_skew_at) ? 1 : 0;
      drive_fifo();
      tick();
      check_eq("s_ready", 64'(smp_sready), 64'(pushes < nw && occ <= 7));
      check_eq("m_valid", 64'(smp_mvalid), 64'(pops < n && occ >= 3));
      check_eq("push", 64'(smp_push), 64'(s_valid && pushes < nw && occ <= 7));
      check_eq("pop", 64'(smp_pop), 64'(m_ready && pops < n && occ >= 3));
      if (smp_push) begin
        if (pushes == 1) push_occ2 = occ;
        pushes++;
      end
      if (smp_pop) begin
        if (pops < n) begin
          px = {bytes[3*pops+2], bytes[3*pops+1], bytes[3*pops]};
          check_eq("pixel", 64'(smp_mdata), 64'(px));
        end
        if (pops < 2) first_px[pops] = smp_mdata;
        pops++;
      end
      if (skew != 0) exp_err = ERR_EN;
      check_eq("run_busy", 64'(busy), 64'd1);
      check_eq("run_done", 64'(done), 64'd0);
      check_eq("run_flush", 64'(fifo_flush), 64'(pops == n));
      check_eq("run_err", 64'(err), 64'(exp_err));
      if (byte_q.size() > peak) peak = byte_q.size();
      if (opt_hold > 0 && cyc == opt_hold - 1) begin
        check_eq("hold_pushes", 64'(pushes), 64'd1);
        check_eq("hold_occ", 64'(byte_q.size()), 64'd8);
      end
      cyc++;
      if (opt_abort_pops != 0 && pops == opt_abort_pops) begin
        reset_abort();
        return;
      end
      if (pops >= n) fin = 1'b1;
    end

    s_valid = 1'b0; m_ready = 1'b0; start = 1'b0; skew = 0;
    drive_fifo();
    check_eq("pop_count", 64'(pops), 64'(n));
    check_eq("push_count", 64'(pushes), 64'(nw));
    check_eq("leftover", 64'(byte_q.size()), 64'(8 * nw - 3 * n));
    check_eq("occ_peak_le_depth", 64'(peak <= 15), 64'd1);
    if (opt_hold > 0) check_eq("second_push_occ", 64'(push_occ2), 64'd5);
    if (opt_directed) begin
      check_eq("first_pixel0", 64'(first_px[0]), 64'h384758);
      check_eq("first_pixel1", 64'(first_px[1]), 64'h253267);
    end
    tick();
    check_eq("flush_pulse", 64'(smp_flush), 64'd1);
    check_eq("end_done", 64'(done), 64'd1);
    check_eq("end_busy", 64'(busy), 64'd0);
    check_eq("end_flush", 64'(fifo_flush), 64'd0);
    check_eq("end_err", 64'(err), 64'(exp_err));
    tick();
    check_eq("done_one_cycle", 64'(done), 64'd0);
    check_eq("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic zero_frame();
    start = 1'b1; num_pix = '0; s_valid = 1'b1; m_ready = 1'b1; skew = 0;
    drive_fifo();
    tick();
    start = 1'b0;
    exp_err = 1'b0;
    check_eq("zero_push", 64'(smp_push), 64'd0);
    check_eq("zero_done", 64'(done), 64'd1);
    check_eq("zero_busy", 64'(busy), 64'd0);
    check_eq("zero_err", 64'(err), 64'd0);
    tick();
    check_eq("zero_push2", 64'(smp_push), 64'd0);
    check_eq("zero_pop2", 64'(smp_pop), 64'd0);
    check_eq("zero_done2", 64'(done), 64'd0);
    check_eq("zero_busy2", 64'(busy), 64'd0);
  endtask

  task automatic set_opts(input int hold, input int restart_at, input int abort_pops,
                          input int skew_at, input int vp, input int rp, input bit directed);
    opt_hold = hold; opt_restart_at = restart_at; opt_abort_pops = abort_pops;
    opt_skew_at = skew_at; opt_vp = vp; opt_rp = rp; opt_directed = directed;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt, chk_cnt);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; num_pix = '0; s_data = '0;
    s_valid = 1'b1; m_ready = 1'b1; skew = 0; exp_err = 1'b0;
    drive_fifo();
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i > 0) begin
        check_eq("rst_s_ready", 64'(smp_sready), 64'd0);
        check_eq("rst_m_valid", 64'(smp_mvalid), 64'd0);
        check_eq("rst_push", 64'(smp_push), 64'd0);
      end
      check_eq("rst_busy_r", 64'(busy), 64'd0);
      check_eq("rst_done_r", 64'(done), 64'd0);
      check_eq("rst_flush_r", 64'(fifo_flush), 64'd0);
      check_eq("rst_err_r", 64'(err), 64'd0);
    end
    reset = 1'b0;

    set_opts(0, -1, 0, -1, 100, 100, 1'b1);   // directed words, full throughput
    run_frame(8);
    set_opts(20, -1, 0, -1, 100, 100, 1'b0);  // downstream stalled 20 cycles
    run_frame(8);
    set_opts(0, 0, 0, -1, 100, 100, 1'b0);    // single pixel, start during RUN
    run_frame(1);
    zero_frame();
    set_opts(0, -1, 2, -1, 100, 100, 1'b0);   // reset after two pixels
    run_frame(8);
    set_opts(0, -1, 0, 3, 80, 80, 1'b0);      // fifo_count skewed for one cycle
    run_frame(12);
    for (int k = 0; k < 8; k++) begin
      set_opts(0, int'($urandom_range(0, 30)), 0, -1,
               int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), 1'b0);
      run_frame(int'($urandom_range(1, 40)));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
